bcd_addsub_serial: RTL and testbench

//  Digit-serial, parametrised N-digit packed-BCD adder/subtractor with valid/ready handshakes.

---
 rtl/bcd_pkg.sv | 15 +
 rtl/bcd_addsub_serial_if.sv | 29 ++
 rtl/bcd_digit_cell.sv | 26 ++
 rtl/bcd_addsub_serial.sv | 125 ++++++++++++
 tb/tb_bcd_addsub_serial.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared packed-BCD types, constants and the nine's-complement helper for the decimal datapath.
// Purely combinational definitions; no latency and no flow control of their own.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  typedef logic [3:0] bcd_digit_t;

  // Wraps mod 16 so that invalid digits still produce a defined pattern.
  function automatic bcd_digit_t nines_comp(input bcd_digit_t b);
    return BCD_MAX - b;
  endfunction

endpackage

// File: rtl/bcd_addsub_serial_if.sv
// Operand-request and result handshake bundle for the serial BCD adder/subtractor.
// master drives the request and out_ready; slave returns in_ready and the held result.
interface bcd_addsub_serial_if #(
  parameter int DIGITS = 4
);

  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   in_a;
  logic [4*DIGITS-1:0]   in_b;
  logic                  in_sub;
  logic                  in_cin;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_sum;
  logic                  out_cout;
  logic                  out_err;

  modport master (
    output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_err
  );

endinterface

// File: rtl/bcd_digit_cell.sv
// Single-digit decimal add with +6 correction: (a, b, cin) -> (d, cout).
// Combinational, zero latency; no handshake.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  output bcd_digit_t d,
  output logic       cout
);

  logic [4:0] s;

  always_comb begin
    s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (s > {1'b0, BCD_MAX}) begin
      d    = s[3:0] + BCD_CORR;
      cout = 1'b1;
    end else begin
      d    = s[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_addsub_serial.sv
// Digit-serial packed-BCD add/subtract, DPC digits per clock; result valid DIGITS/DPC edges after accept.
// Accepts only in IDLE; result is held stable until out_ready, and no new operand is taken meanwhile.
module bcd_addsub_serial
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DPC    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  bcd_addsub_serial_if.slave  bus
);

  localparam int STEPS = DIGITS / DPC;
  localparam int W     = 4 * DIGITS;
  localparam int SW    = 4 * DPC;
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if (DIGITS < 1 || DPC < 1 || (DIGITS % DPC) != 0) begin : g_bad_param
    $error("bcd_addsub_serial: DIGITS must be a positive multiple of DPC");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    a_sr;
  logic [W-1:0]    b_sr;
  logic            carry;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            out_cout_q;
  logic            out_err_q;
  logic [W-1:0]    out_sum_q;

  logic [W-1:0]    b_comp;
  logic            raw_err;
  logic [DPC:0]    c_chain;
  logic [SW-1:0]   step_sum;
  logic [W-1:0]    sum_next;

  // Error detection looks at the raw B, before any complementing.
  always_comb begin
    b_comp  = '0;
    raw_err = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      b_comp[4*i +: 4] = bus.in_sub ? nines_comp(bus.in_b[4*i +: 4]) : bus.in_b[4*i +: 4];
      if (bus.in_a[4*i +: 4] > BCD_MAX || bus.in_b[4*i +: 4] > BCD_MAX) begin
        raw_err = 1'b1;
      end
    end
  end

  assign c_chain[0] = carry;

  for (genvar g = 0; g < DPC; g++) begin : g_cell
    bcd_digit_cell u_cell (
      .a    (a_sr[4*g +: 4]),
      .b    (b_sr[4*g +: 4]),
      .cin  (c_chain[g]),
      .d    (step_sum[4*g +: 4]),
      .cout (c_chain[g+1])
    );
  end

  // New digits enter at the top so the first step ends up in digit 0.
  assign sum_next = (out_sum_q >> SW) | (W'(step_sum) << (W - SW));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      a_sr        <= '0;
      b_sr        <= '0;
      carry       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_cout_q  <= 1'b0;
      out_err_q   <= 1'b0;
      out_sum_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sr       <= bus.in_a;
            b_sr       <= b_comp;
            carry      <= bus.in_cin;
            out_err_q  <= raw_err;
            cnt        <= '0;
            in_ready_q <= 1'b0;
            state      <= CALC;
          end
        end
        CALC: begin
          a_sr      <= a_sr >> SW;
          b_sr      <= b_sr >> SW;
          carry     <= c_chain[DPC];
          out_sum_q <= sum_next;
          cnt       <= cnt + 1'b1;
          if (cnt == LAST) begin
            out_cout_q  <= c_chain[DPC];
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cout  = out_cout_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Three instances (DPC = 1, 2, 4) driven in lockstep; a per-instance scoreboard checks results and latency.
module tb_bcd_addsub_serial;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   nchecks = 0;
  int   nerr = 0;

  logic        drv_valid = 1'b0;
  logic [15:0] drv_a = '0;
  logic [15:0] drv_b = '0;
  logic        drv_sub = 1'b0;
  logic        drv_cin = 1'b0;
  logic        drv_ready = 1'b1;

  exp_t exp_q [3][$];
  int   lat_exp [3] = '{4, 2, 1};

  logic [2:0]  ov;
  logic [2:0]  ir;
  logic [2:0]  ocout;
  logic [2:0]  oerr;
  logic [15:0] osum [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_addsub_serial_if #(.DIGITS(4)) if1 ();
  bcd_addsub_serial_if #(.DIGITS(4)) if2 ();
  bcd_addsub_serial_if #(.DIGITS(4)) if4 ();

  bcd_addsub_serial #(.DIGITS(4), .DPC(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  bcd_addsub_serial #(.DIGITS(4), .DPC(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  bcd_addsub_serial #(.DIGITS(4), .DPC(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  assign if1.in_valid = drv_valid;  assign if2.in_valid = drv_valid;  assign if4.in_valid = drv_valid;
  assign if1.in_a = drv_a;          assign if2.in_a = drv_a;          assign if4.in_a = drv_a;
  assign if1.in_b = drv_b;          assign if2.in_b = drv_b;          assign if4.in_b = drv_b;
  assign if1.in_sub = drv_sub;      assign if2.in_sub = drv_sub;      assign if4.in_sub = drv_sub;
  assign if1.in_cin = drv_cin;      assign if2.in_cin = drv_cin;      assign if4.in_cin = drv_cin;
  assign if1.out_ready = drv_ready; assign if2.out_ready = drv_ready; assign if4.out_ready = drv_ready;

  assign ov    = {if4.out_valid, if2.out_valid, if1.out_valid};
  assign ir    = {if4.in_ready, if2.in_ready, if1.in_ready};
  assign ocout = {if4.out_cout, if2.out_cout, if1.out_cout};
  assign oerr  = {if4.out_err, if2.out_err, if1.out_err};
  assign osum[0] = if1.out_sum;
  assign osum[1] = if2.out_sum;
  assign osum[2] = if4.out_sum;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    nchecks++;
    assert (got === expv) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, got, expv);
    end
  endtask

  // Decimal reference: works on whole numbers, valid digits only.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic sub, input logic cin);
    int av = 0;
    int bv = 0;
    int r;
    exp_t e;
    for (int i = 3; i >= 0; i--) begin
      av = av * 10 + int'(a[4*i +: 4]);
      bv = bv * 10 + int'(b[4*i +: 4]);
    end
    if (sub) bv = 9999 - bv;
    r = av + bv + int'(cin);
    e.cout = (r >= 10000);
    e.err  = 1'b0;
    r = r % 10000;
    for (int i = 0; i < 4; i++) begin
      e.sum[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return e;
  endfunction

  function automatic logic [15:0] rand_bcd();
    logic [15:0] x;
    for (int i = 0; i < 4; i++) x[4*i +: 4] = 4'($urandom_range(0, 9));
    return x;
  endfunction

  task automatic monitor();
    int   acc_cyc [3] = '{0, 0, 0};
    logic [2:0] ov_prev = 3'b000;
    exp_t e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (rst_n && drv_valid && ir[k]) acc_cyc[k] = cyc;
        if (rst_n && ov[k] && !ov_prev[k])
          chk($sformatf("latency_dut%0d", k), 32'(cyc - acc_cyc[k] - 1), 32'(lat_exp[k]));
        if (rst_n && ov[k] && drv_ready) begin
          if (exp_q[k].size() == 0) begin
            chk($sformatf("unexpected_output_dut%0d", k), 32'(exp_q[k].size()), 32'd1);
          end else begin
            e = exp_q[k].pop_front();
            chk($sformatf("sum_dut%0d", k),  32'(osum[k]), 32'(e.sum));
            chk($sformatf("cout_dut%0d", k), 32'(ocout[k]), 32'(e.cout));
            chk($sformatf("err_dut%0d", k),  32'(oerr[k]), 32'(e.err));
          end
        end
      end
      ov_prev = rst_n ? ov : 3'b000;
    end
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                       input logic cin, input exp_t e);
    int n = 0;
    while (ir !== 3'b111 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", 32'(n < 50), 32'd1);
    drv_a = a; drv_b = b; drv_sub = sub; drv_cin = cin; drv_valid = 1'b1;
    for (int k = 0; k < 3; k++) exp_q[k].push_back(e);
    @(posedge clk); #1;
    drv_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_wait", 32'(n < 60), 32'd1);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rs;
    logic        rc;
    int          n;

    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(ir), 32'h7);
    chk("rst_out_valid", 32'(ov), 32'h0);
    chk("rst_out_sum", 32'(osum[0]), 32'h0);
    chk("rst_cout_err", 32'({ocout, oerr}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(16'h1234, 16'h5678, 1'b0, 1'b0, '{16'h6912, 1'b0, 1'b0});
    drain();
    do_op(16'h9999, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0});
    drain();
    do_op(16'h5000, 16'h1234, 1'b1, 1'b1, '{16'h3766, 1'b1, 1'b0});
    drain();
    do_op(16'h1234, 16'h5000, 1'b1, 1'b1, '{16'h6234, 1'b0, 1'b0});
    drain();
    do_op(16'h00A0, 16'h0000, 1'b0, 1'b0, '{16'h0100, 1'b0, 1'b1});
    drain();

    for (int t = 0; t < 8; t++) begin
      ra = rand_bcd();
      rb = rand_bcd();
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      do_op(ra, rb, rs, rc, model(ra, rb, rs, rc));
      drain();
    end

    // Result held with out_ready low while in_valid toggles.
    drv_ready = 1'b0;
    do_op(16'h2468, 16'h1357, 1'b0, 1'b0, '{16'h3825, 1'b0, 1'b0});
    n = 0;
    while (ov[0] !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("hold_wait", 32'(n < 20), 32'd1);
    for (int i = 0; i < 5; i++) begin
      drv_a = 16'h4444;
      drv_b = 16'h4444;
      drv_valid = (i % 2 == 0);
      @(negedge clk);
      chk("hold_sum", 32'(osum[0]), 32'h3825);
      chk("hold_flags", 32'({ov[0], ocout[0], oerr[0]}), 32'h4);
      chk("hold_in_ready", 32'(ir), 32'h0);
      @(posedge clk); #1;
    end
    drv_valid = 1'b0;
    drv_ready = 1'b1;
    drain();
    chk("release_in_ready", 32'(ir), 32'h7);
    do_op(16'h0001, 16'h0002, 1'b0, 1'b0, '{16'h0003, 1'b0, 1'b0});
    drain();

    // Reset in the middle of an op: nothing may come out of it.
    drv_ready = 1'b0;
    drv_a = 16'h0A00; drv_b = 16'h0001; drv_sub = 1'b0; drv_cin = 1'b0; drv_valid = 1'b1;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) exp_q[k].delete();
    #1;
    chk("abort_out_valid", 32'(ov), 32'h0);
    chk("abort_out_sum", 32'(osum[0]), 32'h0);
    chk("abort_cout_err", 32'({ocout, oerr}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drv_ready = 1'b1;
    @(posedge clk); #1;
    chk("abort_in_ready", 32'(ir), 32'h7);
    do_op(16'h0500, 16'h0500, 1'b0, 1'b0, '{16'h1000, 1'b0, 1'b0});
    drain();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
